// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back port arbiter between a single-cycle ALU result and
// a queued stream of multi-cycle (load/mul) results.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   alu_valid/rd/data/wsp ALU result; cannot be stalled, always wins the port
//   mem_valid/rd/data/wsp memory result offer; accepted when mem_ready is 1
//   mem_ready             queue has room (count < DEPTH), low during reset
//   RegWrite              registered register-file write enable
//   Write_register        registered write address (holds when idle)
//   Write_d               registered write data (holds when idle)
//   pend_mask             one bit per architectural register with a queued
//                         write still outstanding
//
// Register 31 is XZR unless the producer marks it as an SP write (wsp=1);
// XZR writes are dropped before they reach the queue or the port.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        alu_wsp,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [63:0] mem_data,
  input  logic        mem_wsp,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [63:0] Write_d,
  output logic [31:0] pend_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] q_vld;
  logic [4:0]       q_rd   [DEPTH];
  logic [63:0]      q_data [DEPTH];

  logic        alu_keep, mem_keep, push, pop;
  logic        vld_p0;
  logic [4:0]  wr_rd_p0;
  logic [63:0] wr_data_p0;

  // ready depends only on the pre-pop count, so a full queue never accepts
  // even on an edge where its head drains.
  assign mem_ready = !reset && (count < CNT_W'(DEPTH));

  assign alu_keep = alu_valid && !((alu_rd == 5'd31) && !alu_wsp);
  assign mem_keep = !((mem_rd == 5'd31) && !mem_wsp);
  assign push     = mem_valid && mem_ready && mem_keep;
  assign pop      = !alu_keep && (count != '0);

  // ---- stage p0: port selection (ALU first, then queue head) ----
  always_comb begin
    vld_p0     = 1'b0;
    wr_rd_p0   = '0;
    wr_data_p0 = '0;
    if (alu_keep) begin
      vld_p0     = 1'b1;
      wr_rd_p0   = alu_rd;
      wr_data_p0 = alu_data;
    end else if (pop) begin
      vld_p0     = 1'b1;
      wr_rd_p0   = q_rd[rd_ptr];
      wr_data_p0 = q_data[rd_ptr];
    end
  end

  // ---- stage p1: registered write port and queue control ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_d        <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      q_vld          <= '0;
    end else begin
      RegWrite <= vld_p0;
      if (vld_p0) begin
        Write_register <= wr_rd_p0;
        Write_d        <= wr_data_p0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + PTR_W'(1);
        q_vld[wr_ptr] <= 1'b1;
      end
      // A pop never targets the slot being pushed: push needs count < DEPTH,
      // so the write pointer cannot equal a valid head slot.
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        q_vld[rd_ptr] <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue payload needs no reset; q_vld alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= mem_rd;
      q_data[wr_ptr] <= mem_data;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) pend_mask = pend_mask | (32'd1 << q_rd[i]);
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, is the number of entries in the memory-result queue; it SHALL be a power of two and at least 2.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_valid  input  1  a single-cycle result is present this cycle; it cannot be stalled.
REQ-005 alu_rd  input  5  destination register of the ALU result.
REQ-006 alu_data  input  64  ALU result value.
REQ-007 alu_wsp  input  1  an ALU result to register 31 targets SP (1) or XZR (0).
REQ-008 mem_valid  input  1  a multi-cycle (load/mul) result is offered.
REQ-009 mem_ready  output  1  the block can accept a memory result this cycle.
REQ-010 mem_rd  input  5  destination register of the memory result.
REQ-011 mem_data  input  64  memory result value.
REQ-012 mem_wsp  input  1  a memory result to register 31 targets SP (1) or XZR (0).
REQ-013 RegWrite  output  1  registered write enable to the register file.
REQ-014 Write_register  output  5  registered write address.
REQ-015 Write_d  output  64  registered write data.
REQ-016 pend_mask  output  32  bit n set means a queued write to Xn is outstanding; used for issue-stage hazard checks.

Function
REQ-017 A memory result SHALL be accepted on any rising edge where mem_valid and mem_ready are both 1.
REQ-018 mem_ready SHALL equal (queue count < DEPTH), computed from the count before any same-cycle pop; a push into a full queue SHALL NOT occur even if a pop happens that cycle.
REQ-019 An accepted memory result with rd=31 and wsp=0 (XZR) SHALL be discarded, not enqueued.
REQ-020 Any other accepted memory result SHALL be enqueued in FIFO order.
REQ-021 Port selection each cycle, in priority order:
  - a non-discarded ALU result;
  - else the queue head, if the queue is non-empty;
  - else no write.
REQ-022 An ALU result with rd=31 and alu_wsp=0 SHALL be discarded; in that cycle the port is free for the queue head.
REQ-023 The selected write SHALL appear on RegWrite/Write_register/Write_d exactly one cycle after selection (latency 1).
REQ-024 On cycles with no selection, RegWrite SHALL be 0 and Write_register/Write_d SHALL hold their previous values.
REQ-025 A write to register 31 with wsp=1 SHALL drive Write_register=31 (SP update).
REQ-026 The queue head SHALL be popped in the same edge on which it is selected; push and pop SHALL be allowed on the same edge when count < DEPTH.
REQ-027 The queue pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-028 pend_mask SHALL be the combinational OR of one-hot(rd) over all valid queue entries; an entry SHALL stop contributing on the edge it is popped.
REQ-029 Ordering (WAW) is the issue stage's responsibility: it SHALL NOT issue an ALU write to a register whose pend_mask bit is set; the block does not reorder.
REQ-030 A continuous ALU stream SHALL be allowed to hold the queue indefinitely, with mem_ready low while the queue is full; there is no starvation counter.

Reset
REQ-031 While reset is high, the block SHALL immediately force:
  - RegWrite=0, Write_register=0, Write_d=0;
  - queue empty, pend_mask=0;
  - mem_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; no queued write SHALL reach the port after deassertion.
REQ-033 mem_ready SHALL return to 1 on the first cycle after reset deasserts.

Verification
REQ-034 ALU only: alu_valid=1, rd=3, data=0x1122334455667788 -> next cycle RegWrite=1, Write_register=3, Write_d=0x1122334455667788.
REQ-035 Conflict: same cycle ALU rd=1 data=0xA and memory rd=2 data=0xB accepted -> cycle+1 writes X1=0xA with pend_mask=0x4; cycle+2 writes X2=0xB; pend_mask=0 after.
REQ-036 Queue full: ALU held valid with rd=5, two memory results rd=6 then rd=7 accepted -> mem_ready=0, pend_mask=0xC0; ALU dropped -> writes X6 then X7 on consecutive cycles, mem_ready=1 from the first pop edge.
REQ-037 Register 31: ALU rd=31 wsp=0 -> RegWrite stays 0 and a pending queue head drains that cycle; ALU rd=31 wsp=1 data=0x8000 -> Write_register=31, Write_d=0x8000.
REQ-038 Reset mid-operation: queue holding 2 entries, reset asserted between edges -> RegWrite=0 and pend_mask=0 before the next edge; after deassert no write occurs and mem_ready=1.
